mem_axi_bridge: RTL and testbench

//   Responder end of the cache memory port (mem_en/mem_we/mem_size/mem_addr/mem_data_*/mem_addr_o/mem_data_o).

---
 rtl/mem_axi_bridge_pkg.sv | 45 ++++
 rtl/mem_axi_bridge.sv | 168 ++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_bridge_pkg.sv
// Shared types and helpers for the cache-port to single-beat AXI4 bridge.
// Holds bus widths, size/response encodings, the FSM state type and strobe generation.
package mem_axi_bridge_pkg;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } bridge_state_e;

  // Size code 3 is not a legal cache size; it is carried as a full word.
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : {1'b0, size};
  endfunction

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      MEM_B:   strb = 4'b0001 << addr_lo;
      MEM_H:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'hF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// Responder for a cache memory port: each single-word request becomes one
// single-beat (len=0, INCR) AXI4 read or write; all outputs come from flops.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  // cache side
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [W_ADDR-1:0] mem_addr,
  input  logic [W_DATA-1:0] mem_data_w,
  output logic [W_DATA-1:0] mem_data_r,
  output logic              mem_addr_o,
  output logic              mem_data_o,
  output logic              bus_err,
  // AR / R
  output logic [W_ADDR-1:0] axi_araddr,
  output logic [2:0]        axi_arsize,
  output logic [3:0]        axi_arid,
  output logic [7:0]        axi_arlen,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [W_DATA-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  // AW / W / B
  output logic [W_ADDR-1:0] axi_awaddr,
  output logic [2:0]        axi_awsize,
  output logic [3:0]        axi_awid,
  output logic [7:0]        axi_awlen,
  output logic [1:0]        axi_awburst,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [W_DATA-1:0] axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wlast,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  bridge_state_e     state_q;
  logic [W_ADDR-1:0] addr_q;
  logic [W_DATA-1:0] wdata_q;
  logic [W_DATA-1:0] rdata_q;
  logic [2:0]        axsize_q;
  logic [3:0]        wstrb_q;
  logic              arvalid_q, rready_q;
  logic              awvalid_q, wvalid_q, bready_q;
  logic              mem_addr_o_q, mem_data_o_q, bus_err_q;

  // A write channel is still pending while its valid is up and not yet accepted.
  logic aw_pend_d, w_pend_d;
  always_comb begin
    aw_pend_d = awvalid_q & ~axi_awready;
    w_pend_d  = wvalid_q  & ~axi_wready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      axsize_q     <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      mem_addr_o_q <= 1'b0;
      mem_data_o_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      mem_addr_o_q <= 1'b0;
      mem_data_o_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_en) begin
            addr_q   <= mem_addr;
            wdata_q  <= mem_data_w;
            axsize_q <= size_to_axsize(mem_size);
            wstrb_q  <= size_to_wstrb(mem_size, mem_addr[1:0]);
            if (mem_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RADDR;
            end
          end
        end
        ST_RADDR: begin
          if (axi_arready) begin
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b1;
            mem_addr_o_q <= 1'b1;
            state_q      <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (axi_rvalid) begin
            rready_q     <= 1'b0;
            rdata_q      <= axi_rdata;
            mem_data_o_q <= 1'b1;
            state_q      <= ST_DONE;
            if (axi_rresp != AXI_OKAY) bus_err_q <= 1'b1;
          end
        end
        ST_WADDR: begin
          awvalid_q <= aw_pend_d;
          wvalid_q  <= w_pend_d;
          if (!aw_pend_d && !w_pend_d) begin
            mem_addr_o_q <= 1'b1;
            bready_q     <= 1'b1;
            state_q      <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (axi_bvalid) begin
            bready_q     <= 1'b0;
            mem_data_o_q <= 1'b1;
            state_q      <= ST_DONE;
            if (axi_bresp != AXI_OKAY) bus_err_q <= 1'b1;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_data_r  = rdata_q;
  assign mem_addr_o  = mem_addr_o_q;
  assign mem_data_o  = mem_data_o_q;
  assign bus_err     = bus_err_q;

  assign axi_araddr  = addr_q;
  assign axi_arsize  = axsize_q;
  assign axi_arid    = AXI_ID;
  assign axi_arlen   = 8'd0;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

  assign axi_awaddr  = addr_q;
  assign axi_awsize  = axsize_q;
  assign axi_awid    = AXI_ID;
  assign axi_awlen   = 8'd0;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed plus randomized bench for mem_axi_bridge; the bench plays cache initiator
// and AXI slave, and predicts each transaction from address/size/response rules.
module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_data_w, mem_data_r;
  logic        mem_addr_o, mem_data_o, bus_err;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [3:0]  axi_arid, axi_awid, axi_wstrb;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready;

  int   tests = 0;
  int   fails = 0;
  logic err_model = 1'b0;

  mem_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .bus_err(bus_err),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arid(axi_arid),
    .axi_arlen(axi_arlen), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awid(axi_awid),
    .axi_awlen(axi_awlen), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_bits();
    return 32'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, mem_addr_o, mem_data_o});
  endfunction

  // One complete transaction from an IDLE-cycle negedge. da: AR/AW ready delay,
  // dw: W ready delay, dr: R/B valid delay after the address (and data) handshakes.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input int da, input int dw, input int dr,
                         input logic [1:0] resp, input logic [31:0] rd, input bit chk_lat);
    int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    int ar_c = 0, aw_c = 0, w_c = 0, rsp_c = 0;
    int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, rsp_cyc = 0;
    int addr_cyc = -1, data_cyc = -1, n_addr = 0;
    bit ar_f = 0, aw_f = 0, w_f = 0, r_f = 0, b_f = 0;
    bit ar_v = 0, aw_v = 0, w_v = 0;
    logic [2:0] exp_sz;
    logic [3:0] exp_strb;
    exp_sz = (size == 2'd3) ? 3'd2 : {1'b0, size};
    if (size == 2'd0)      exp_strb = 4'(1 << (addr % 4));
    else if (size == 2'd1) exp_strb = 4'(3 << (addr & 32'd2));
    else                   exp_strb = 4'd15;

    mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_size = size; mem_data_w = wd;
    for (int cyc = 1; cyc <= 100 && data_cyc < 0; cyc++) begin
      @(negedge clk);
      axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
      if (r_hs > 0) axi_rvalid = 1'b0;
      if (b_hs > 0) axi_bvalid = 1'b0;
      chk("pulse_overlap", 32'(mem_addr_o & mem_data_o), 32'd0);
      if (ar_v) chk(ar_f ? "arvalid_drop" : "arvalid_hold", 32'(axi_arvalid), 32'(!ar_f));
      if (aw_v) chk(aw_f ? "awvalid_drop" : "awvalid_hold", 32'(axi_awvalid), 32'(!aw_f));
      if (w_v)  chk(w_f  ? "wvalid_drop"  : "wvalid_hold",  32'(axi_wvalid),  32'(!w_f));
      if (r_f)  chk("rready_drop", 32'(axi_rready), 32'd0);
      if (b_f)  chk("bready_drop", 32'(axi_bready), 32'd0);
      ar_f = 0; aw_f = 0; w_f = 0; r_f = 0; b_f = 0;
      if (mem_addr_o) begin n_addr++; addr_cyc = cyc; mem_en = 1'b0; end
      if (mem_data_o) data_cyc = cyc;
      // response channels use only handshakes from earlier cycles
      if (ar_hs > 0 && r_hs == 0) begin
        if (rsp_c >= dr) begin
          axi_rvalid = 1'b1; axi_rdata = rd; axi_rresp = resp;
          if (axi_rready) begin r_f = 1; r_hs++; rsp_cyc = cyc; end
        end else rsp_c++;
      end
      if (aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
        if (rsp_c >= dr) begin
          axi_bvalid = 1'b1; axi_bresp = resp;
          if (axi_bready) begin b_f = 1; b_hs++; rsp_cyc = cyc; end
        end else rsp_c++;
      end
      if (axi_arvalid) begin
        if (ar_c == 0) begin
          chk("araddr", axi_araddr, addr);
          chk("arsize", 32'(axi_arsize), 32'(exp_sz));
          chk("ar_fixed", {16'd0, axi_arid, axi_arlen, 2'd0, axi_arburst}, 32'h0000_0001);
        end
        if (ar_c >= da) begin axi_arready = 1'b1; ar_f = 1; ar_hs++; ar_cyc = cyc; end
        else ar_c++;
      end
      if (axi_awvalid) begin
        if (aw_c == 0) begin
          chk("awaddr", axi_awaddr, addr);
          chk("awsize", 32'(axi_awsize), 32'(exp_sz));
          chk("aw_fixed", {16'd0, axi_awid, axi_awlen, 2'd0, axi_awburst}, 32'h0000_0001);
        end
        if (aw_c >= da) begin axi_awready = 1'b1; aw_f = 1; aw_hs++; aw_cyc = cyc; end
        else aw_c++;
      end
      if (axi_wvalid) begin
        if (w_c == 0) begin
          chk("wdata", axi_wdata, wd);
          chk("wstrb_wlast", {27'd0, axi_wlast, axi_wstrb}, {27'd0, 1'b1, exp_strb});
        end
        if (w_c >= dw) begin axi_wready = 1'b1; w_f = 1; w_hs++; w_cyc = cyc; end
        else w_c++;
      end
      ar_v = axi_arvalid; aw_v = axi_awvalid; w_v = axi_wvalid;
    end
    chk("txn_complete", 32'(data_cyc > 0), 32'd1);
    chk("addr_pulses", n_addr, 1);
    if (resp != 2'b00) err_model = 1'b1;
    chk("bus_err", 32'(bus_err), 32'(err_model));
    if (we) begin
      chk("wr_handshakes", {ar_hs[7:0], aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 32'h0001_0101);
      chk("wr_addr_timing", addr_cyc, ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 1);
    end else begin
      chk("rd_handshakes", {ar_hs[7:0], aw_hs[7:0], w_hs[7:0], r_hs[7:0]}, 32'h0100_0001);
      chk("rd_addr_timing", addr_cyc, ar_cyc + 1);
      chk("mem_data_r", mem_data_r, rd);
    end
    chk("data_timing", data_cyc, rsp_cyc + 1);
    if (chk_lat) chk("best_latency", data_cyc, 3);
    mem_en = 1'b0;
    @(negedge clk);
    chk("idle_after_done", ctl_bits(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_data_w = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", ctl_bits(), 32'd0);
    chk("reset_err", 32'(bus_err), 32'd0);
    chk("reset_rdata", mem_data_r, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(0, 32'h1000_0004, 2'd2, 32'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1);
    run_txn(1, 32'h2000_0003, 2'd0, 32'hAA00_0000, 0, 0, 0, 2'b00, 32'h0, 1);
    run_txn(1, 32'h3000_0010, 2'd2, 32'h1234_5678, 5, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1, 32'h3000_0020, 2'd1, 32'h5566_0000, 0, 4, 1, 2'b00, 32'h0, 0);
    // write-back immediately followed by a refill from a different address
    run_txn(1, 32'h4000_0040, 2'd3, 32'hCAFE_F00D, 0, 0, 0, 2'b00, 32'h0, 1);
    run_txn(0, 32'h5000_0080, 2'd2, 32'h0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 20; i++)
      run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'b00, $urandom, 0);

    run_txn(0, 32'h6000_0000, 2'd2, 32'h0, 0, 0, 0, 2'b10, 32'h1111_2222, 0);
    run_txn(1, 32'h6000_0004, 2'd2, 32'h3333_4444, 1, 1, 1, 2'b00, 32'h0, 0);
    run_txn(0, 32'h6000_0008, 2'd0, 32'h0, 0, 2, 2, 2'b00, 32'h5555_6666, 0);

    for (int i = 0; i < 10; i++)
      run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom, 0);

    // reset while the bridge waits in RDATA
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h7000_0000; mem_size = 2'd2;
    @(negedge clk);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0; mem_en = 1'b0;
    chk("rdata_wait", ctl_bits(), 32'b0100010);
    rst = 1'b1;
    #1;
    chk("async_reset_ctl", ctl_bits(), 32'd0);
    chk("async_reset_err", 32'(bus_err), 32'd0);
    err_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", ctl_bits(), 32'd0);
    run_txn(0, 32'h7000_0100, 2'd2, 32'h0, 0, 0, 0, 2'b00, 32'h7777_8888, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
